// File: rtl/controlador_sequenciador.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring clocked on the falling edge of CLK,
// with the control word decoded combinationally from the ring state and the IR opcode.
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       HLT,
    output logic [5:0] estado
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] estado_q;
    logic       hlt_q;

    // Halt is taken on the edge that would leave T4, so the ring stays parked in T4.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            estado_q <= T1;
            hlt_q    <= 1'b0;
        end else if (!hlt_q) begin
            if (estado_q == T4 && opcode == OP_HLT) begin
                hlt_q <= 1'b1;
            end else begin
                estado_q <= {estado_q[4:0], estado_q[5]};
            end
        end
    end

    logic cp_d, ep_d, lm_d, ce_d, li_d, ei_d, la_d, ea_d, su_d, eu_d, lb_d, lo_d;
    logic is_mem_op;

    assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

    always_comb begin
        cp_d = 1'b0;
        ep_d = 1'b0;
        lm_d = 1'b0;
        ce_d = 1'b0;
        li_d = 1'b0;
        ei_d = 1'b0;
        la_d = 1'b0;
        ea_d = 1'b0;
        su_d = 1'b0;
        eu_d = 1'b0;
        lb_d = 1'b0;
        lo_d = 1'b0;
        if (!CLR && !hlt_q) begin
            case (estado_q)
                T1: begin
                    ep_d = 1'b1;
                    lm_d = 1'b1;
                end
                T2: cp_d = 1'b1;
                T3: begin
                    ce_d = 1'b1;
                    li_d = 1'b1;
                end
                T4: begin
                    if (is_mem_op) begin
                        ei_d = 1'b1;
                        lm_d = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        ea_d = 1'b1;
                        lo_d = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ce_d = 1'b1;
                        la_d = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ce_d = 1'b1;
                        lb_d = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eu_d = 1'b1;
                        la_d = 1'b1;
                        su_d = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Cp     = cp_d;
    assign Ep     = ep_d;
    assign Lm     = lm_d;
    assign CE     = ce_d;
    assign Li     = li_d;
    assign Ei     = ei_d;
    assign La     = la_d;
    assign Ea     = ea_d;
    assign Su     = su_d;
    assign Eu     = eu_d;
    assign Lb     = lb_d;
    assign Lo     = lo_d;
    assign HLT    = hlt_q;
    assign estado = estado_q;

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Bench for the SAP-1 controller-sequencer: directed scenarios plus randomized
// instruction streams checked against a step-number reference model.
module tb_controlador_sequenciador;

    logic       CLK = 1'b1;
    logic       CLR = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT;
    logic [5:0] estado;

    int total = 0;
    int bad   = 0;

    // Reference model: current T-step number (1..6), halted flag
    int st = 1;
    bit halted_m = 0;

    always #5 CLK = ~CLK;

    controlador_sequenciador dut (
        .CLK(CLK), .CLR(CLR), .opcode(opcode),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE), .Li(Li), .Ei(Ei), .La(La),
        .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .HLT(HLT), .estado(estado)
    );

    // Bit positions in {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
    localparam int B_LA = 5, B_EA = 4, B_SU = 3, B_EU = 2, B_LB = 1, B_LO = 0;

    function automatic logic [11:0] ref_strobes();
        logic [11:0] s;
        s = '0;
        if (CLR || halted_m) return s;
        case (st)
            1: begin s[B_EP] = 1; s[B_LM] = 1; end
            2: s[B_CP] = 1;
            3: begin s[B_CE] = 1; s[B_LI] = 1; end
            4: begin
                if (opcode inside {4'h0, 4'h1, 4'h2}) begin s[B_EI] = 1; s[B_LM] = 1; end
                if (opcode == 4'hE) begin s[B_EA] = 1; s[B_LO] = 1; end
            end
            5: begin
                if (opcode == 4'h0) begin s[B_CE] = 1; s[B_LA] = 1; end
                if (opcode inside {4'h1, 4'h2}) begin s[B_CE] = 1; s[B_LB] = 1; end
            end
            6: begin
                if (opcode inside {4'h1, 4'h2}) begin s[B_EU] = 1; s[B_LA] = 1; end
                if (opcode == 4'h2) s[B_SU] = 1;
            end
            default: ;
        endcase
        return s;
    endfunction

    task automatic check(input string tag);
        logic [11:0] obs, exp;
        logic [5:0]  exp_st;
        obs = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};
        exp = ref_strobes();
        exp_st = 6'b000001 << (st - 1);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s strobes observed=%b expected=%b (step %0d op %h)", tag, obs, exp, st, opcode);
        end
        total++;
        assert (estado === exp_st) else begin
            bad++;
            $error("FAIL %s estado observed=%b expected=%b", tag, estado, exp_st);
        end
        total++;
        assert (HLT === halted_m) else begin
            bad++;
            $error("FAIL %s HLT observed=%b expected=%b", tag, HLT, halted_m);
        end
        total++;
        assert (($countones({Ep, CE, Ei, Ea, Eu}) <= 1) && !(Cp && Ep)) else begin
            bad++;
            $error("FAIL %s bus_excl observed=%b expected=at-most-one", tag, {Cp, Ep, CE, Ei, Ea, Eu});
        end
    endtask

    // One falling edge, model update, then check 2 time units later
    task automatic tick(input string tag);
        @(negedge CLK);
        if (!CLR && !halted_m) begin
            if (st == 4 && opcode == 4'hF) halted_m = 1;
            else st = (st == 6) ? 1 : st + 1;
        end
        #2;
        check(tag);
    endtask

    task automatic clear_pulse(input string tag, input int edges);
        #1 CLR = 1'b1;
        st = 1;
        halted_m = 0;
        #1 check({tag, "_clr_async"});
        repeat (edges) tick({tag, "_clr_held"});
        #1 CLR = 1'b0;
        #1 check({tag, "_clr_release"});
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        opcode = op;
        #1 check({tag, "_t1"});
        repeat (6) tick(tag);
    endtask

    initial begin
        logic [3:0] op;
        int guard;
        int cp_seen;

        // 1. Reset
        CLR = 1'b1;
        #1 check("reset_async");
        tick("reset_held");
        tick("reset_held");
        #1 CLR = 1'b0;
        #1 check("reset_release");

        // 2. LDA, counting Cp across the instruction
        opcode = 4'h0;
        cp_seen = 0;
        repeat (6) begin
            tick("lda");
            cp_seen += int'(Cp);
        end
        total++;
        assert (cp_seen == 1) else begin
            bad++;
            $error("FAIL lda_cp_count observed=%0d expected=1", cp_seen);
        end

        // 3/4. ADD, SUB, OUT, undefined
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'hE, "out");
        run_instr(4'h7, "undef7");

        // Randomized instruction stream with occasional asynchronous clears
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'hE;
                default: op = 4'($urandom_range(3, 13));
            endcase
            opcode = op;
            #1 check("rand_t1");
            guard = 0;
            do begin
                tick("rand");
                if ($urandom_range(0, 24) == 0) clear_pulse("rand", $urandom_range(0, 2));
                guard++;
            end while (st != 1 && guard < 8);
            total++;
            assert (st == 1) else begin
                bad++;
                $error("FAIL rand_ring_bound observed=%0d expected=1", st);
            end
        end

        // 5. HLT freezes in T4
        opcode = 4'hF;
        #1 check("hlt_t1");
        repeat (3) tick("hlt_fetch");
        tick("hlt_set");
        repeat (10) tick("hlt_frozen");
        clear_pulse("hlt", 1);
        tick("post_hlt");

        // 6. Clear mid-T5 of ADD, then a normal instruction
        clear_pulse("pre6", 0);
        opcode = 4'h1;
        repeat (4) tick("add_mid");
        clear_pulse("add_t5", 0);
        run_instr(4'h0, "post_clr_lda");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
